// File: rtl/pwm_breathe_pkg.sv
// Shared mode and direction encodings for the multi-channel PWM breathing controller.
package pwm_breathe_pkg;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'b00,
      MODE_STEADY  = 2'b01,
      MODE_BREATHE = 2'b10,
      MODE_RSVD    = 2'b11
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

endpackage

// File: rtl/pwm_breathe_ch.sv
// One LED channel: mode decode, breathing ramp, boundary-latched duty and PWM compare.
// Optional gamma correction of the compared duty when PWM_BREATHE_GAMMA_EN is defined.
//
// dir state | meaning
// DIR_UP    | breathing duty increments on each step
// DIR_DOWN  | breathing duty decrements on each step
module pwm_breathe_ch
   import pwm_breathe_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         boundary,
   input  logic         step_now,
   input  logic [W-1:0] pwm_cnt,
   input  logic [1:0]   mode,
   input  logic [W-1:0] level,
   output logic         led
);

   localparam logic [W-1:0] DUTY_MAX = '1;

   mode_e        mode_dec;
   dir_e         dir, dir_nxt;
   logic [W-1:0] duty, duty_nxt;
   logic [W-1:0] bduty, bduty_nxt;
   logic [W-1:0] duty_eff;

   assign mode_dec = mode_e'(mode);

   always_ff @(posedge clk) begin
      if (rst) begin
         duty  <= '0;
         bduty <= '0;
         dir   <= DIR_UP;
      end else if (en) begin
         duty  <= duty_nxt;
         bduty <= bduty_nxt;
         dir   <= dir_nxt;
      end
   end

   // All duty/ramp changes happen only on the period boundary so a period is never cut short.
   always_comb begin
      duty_nxt  = duty;
      bduty_nxt = bduty;
      dir_nxt   = dir;
      if (boundary) begin
         unique case (mode_dec)
            MODE_STEADY: begin
               duty_nxt  = level;
               bduty_nxt = '0;
               dir_nxt   = DIR_UP;
            end
            MODE_BREATHE: begin
               if (step_now) begin
                  if (dir == DIR_UP) bduty_nxt = bduty + W'(1);
                  else               bduty_nxt = bduty - W'(1);
                  if (bduty_nxt == DUTY_MAX)  dir_nxt = DIR_DOWN;
                  else if (bduty_nxt == '0)   dir_nxt = DIR_UP;
               end
               duty_nxt = bduty_nxt;
            end
            default: begin
               duty_nxt  = '0;
               bduty_nxt = '0;
               dir_nxt   = DIR_UP;
            end
         endcase
      end
   end

`ifdef PWM_BREATHE_GAMMA_EN
   logic [2*W-1:0] duty_sq;
   assign duty_sq  = {{W{1'b0}}, duty} * {{W{1'b0}}, duty};
   // Full scale is pinned so a "fully on" request stays fully on after correction.
   assign duty_eff = (duty == DUTY_MAX) ? DUTY_MAX : duty_sq[2*W-1:W];
`else
   assign duty_eff = duty;
`endif

   always_ff @(posedge clk) begin
      if (rst)     led <= 1'b0;
      else if (en) led <= (pwm_cnt < duty_eff);
   end

endmodule

// File: rtl/pwm_breathe_array.sv
// Shared PWM timebase and breathing-step prescaler driving CH independent LED channels.
// Build option: PWM_BREATHE_GAMMA_EN selects gamma-corrected duty in every channel.
module pwm_breathe_array
   import pwm_breathe_pkg::*;
#(
   parameter int CH       = 4,
   parameter int W        = 8,
   parameter int STEP_DIV = 300
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [2*CH-1:0] mode,
   input  logic [W*CH-1:0] level,
   output logic [CH-1:0]   led,
   output logic            step
);

   localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   // Period is 2^W-1 cycles, so the counter's last value is 2^W-2.
   localparam logic [W-1:0]  CNT_LAST = {{(W-1){1'b1}}, 1'b0};
   localparam logic [PW-1:0] PER_LAST = PW'(STEP_DIV - 1);

   logic [W-1:0]  pwm_cnt;
   logic [PW-1:0] per_cnt;
   logic          boundary;
   logic          step_now;

   assign boundary = en && (pwm_cnt == CNT_LAST);
   assign step_now = boundary && (per_cnt == PER_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt <= '0;
         per_cnt <= '0;
         step    <= 1'b0;
      end else begin
         step <= step_now;
         if (en) begin
            pwm_cnt <= boundary ? '0 : pwm_cnt + W'(1);
            if (boundary) per_cnt <= step_now ? '0 : per_cnt + PW'(1);
         end
      end
   end

   for (genvar i = 0; i < CH; i++) begin : g_ch
      pwm_breathe_ch #(.W(W)) u_ch (
         .clk      (clk),
         .rst      (rst),
         .en       (en),
         .boundary (boundary),
         .step_now (step_now),
         .pwm_cnt  (pwm_cnt),
         .mode     (mode[2*i +: 2]),
         .level    (level[W*i +: W]),
         .led      (led[i])
      );
   end

endmodule

// File: tb/tb_pwm_breathe_array.sv
// Randomised and directed bench for pwm_breathe_array with a period/step-count reference model.
module tb_pwm_breathe_array;

   localparam int CH = 2;
   localparam int W  = 4;
   localparam int SD = 2;
   localparam int P  = 15;

   logic            clk = 1'b0;
   logic            rst;
   logic            en;
   logic [2*CH-1:0] mode;
   logic [W*CH-1:0] level;
   logic [CH-1:0]   led;
   logic            step;

   always #5 clk = ~clk;

   pwm_breathe_array #(.CH(CH), .W(W), .STEP_DIV(SD)) dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .mode  (mode),
      .level (level),
      .led   (led),
      .step  (step)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Breathing duty after n steps: triangle wave 0..P..0 with period 2P steps.
   function automatic int tri_val(input int n);
      int r;
      r = n % (2 * P);
      return (r <= P) ? r : 2 * P - r;
   endfunction

   function automatic int eff(input int d);
`ifdef PWM_BREATHE_GAMMA_EN
      return (d == P) ? P : (d * d) >> W;
`else
      return d;
`endif
   endfunction

   // Reference model: enabled-cycle position in the period, boundary count, per-channel steps.
   int            m_pcnt;
   int            m_bcnt;
   int            m_duty [CH];
   int            m_nst  [CH];
   logic [CH-1:0] m_led;
   logic          m_step;
   bit            model_ok = 0;

   always @(posedge clk) begin
      bit is_step;
      int md;
      if (rst) begin
         m_pcnt = 0; m_bcnt = 0; m_led = '0; m_step = 0; model_ok = 1;
         for (int i = 0; i < CH; i++) begin m_duty[i] = 0; m_nst[i] = 0; end
      end else if (en) begin
         for (int i = 0; i < CH; i++) m_led[i] = (m_pcnt < eff(m_duty[i]));
         if (m_pcnt == P - 1) begin
            m_bcnt++;
            is_step = (m_bcnt % SD) == 0;
            m_step  = is_step;
            for (int i = 0; i < CH; i++) begin
               md = int'(mode[2*i +: 2]);
               if (md == 1) begin
                  m_duty[i] = int'(level[W*i +: W]); m_nst[i] = 0;
               end else if (md == 2) begin
                  if (is_step) m_nst[i]++;
                  m_duty[i] = tri_val(m_nst[i]);
               end else begin
                  m_duty[i] = 0; m_nst[i] = 0;
               end
            end
            m_pcnt = 0;
         end else begin
            m_step = 0;
            m_pcnt++;
         end
      end else begin
         m_step = 0;
      end
      #1;
      if (model_ok) begin
         chk("led", int'(led), int'(m_led));
         chk("step", int'(step), int'(m_step));
      end
   end

   task automatic set_ch(input int ch, input logic [1:0] md, input logic [W-1:0] lv);
      mode[2*ch +: 2]  = md;
      level[W*ch +: W] = lv;
   endtask

   task automatic count_high(input int ch, input int cycles, output int hi);
      hi = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         hi += int'(led[ch]);
      end
   endtask

   task automatic wait_step();
      int n = 0;
      while (!step && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("step_wait", int'(step), 1);
   endtask

   int hi0, hi1, hi2, bound;
   int exp_lv8, exp_lv12;

   initial begin
`ifdef PWM_BREATHE_GAMMA_EN
      exp_lv8 = 4; exp_lv12 = 9;
`else
      exp_lv8 = 8; exp_lv12 = 12;
`endif
      rst = 1'b1; en = 1'b1; mode = '0; level = '0;
      repeat (3) @(negedge clk);

      // Steady extremes
      set_ch(0, 2'b01, 4'd0);
      set_ch(1, 2'b01, 4'd15);
      rst = 1'b0;
      repeat (32) @(negedge clk);
      count_high(0, P, hi0);
      chk("steady_lv0_high", hi0, 0);
      hi1 = 0;
      for (int k = 0; k < P; k++) begin
         @(negedge clk);
         hi1 += int'(led[1]);
      end
      chk("steady_lv15_high", hi1, 15);

      // Reset mid-period with ch0 steady 8
      set_ch(0, 2'b01, 4'd8);
      repeat (37) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_led", int'(led), 0);
      chk("rst_step", int'(step), 0);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      count_high(0, P, hi0);
      chk("steady_lv8_high", hi0, exp_lv8);

      // Level change mid-period: 4 -> 12 while pwm_cnt = 6
      set_ch(1, 2'b01, 4'd4);
      repeat (31) @(negedge clk);
      bound = 0;
      while (m_pcnt != 6 && bound < 20) begin
         @(negedge clk);
         bound++;
      end
      chk("align_pcnt6", m_pcnt, 6);
      set_ch(1, 2'b01, 4'd12);
      count_high(1, 9, hi1);
      chk("midperiod_old_tail", hi1, 0);
      count_high(1, P, hi1);
      chk("midperiod_new_period", hi1, exp_lv12);

      // Breathing ramp from reset on ch0, ch1 reserved (off)
      rst = 1'b1;
      set_ch(0, 2'b10, 4'd0);
      set_ch(1, 2'b11, 4'd9);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 31; k++) begin
         wait_step();
         count_high(0, P, hi0);
         count_high(0, P, hi2);
         chk("breathe_period_a", hi0, eff(tri_val(k)));
         chk("breathe_period_b", hi2, eff(tri_val(k)));
         chk("step_interval30", int'(step), 1);
         chk("rsvd_off", int'(led[1]), 0);
      end

      // Freeze for 50 cycles mid-ramp, then resume
      repeat (47) @(negedge clk);
      en = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (k > 0) chk("frozen_step", int'(step), 0);
      end
      en = 1'b1;
      repeat (200) @(negedge clk);

      // Random mode/level/enable traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 39) == 0)
            set_ch(int'($urandom_range(0, CH - 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
         en  = ($urandom_range(0, 7) != 0);
         rst = ($urandom_range(0, 599) == 0);
      end
      rst = 1'b0; en = 1'b1;
      repeat (5) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pwm_breathe_array.md
# pwm_breathe_array

Multi-channel LED brightness controller: one shared PWM timebase drives CH independent channels, each configurable as off, steady level, or breathing (duty ramps 0→max→0 continuously). It is the parametrised successor of the single-LED low/high breathing light, adding width, channel count, per-channel mode and glitch-free duty updates. It sits between the board-level control registers and the LED pins.

## Interface
- CH, 4, number of LED channels
- W, 8, PWM resolution in bits; period = 2^W−1 cycles, duty range 0..2^W−1
- STEP_DIV, 300, PWM periods per breathing duty step (≥1)
- clk  input  1  system clock
- rst  input  1  reset; synchronous and active-high
- en  input  1  global enable; 0 freezes timebase, step counter and all channel state
- mode  input  2*CH  per-channel mode, channel i at [2i+1:2i]: 00 off, 01 steady, 10 breathe, 11 reserved (treated as off)
- level  input  W*CH  per-channel steady duty, channel i at [W*i+W−1:W*i]
- led  output  CH  PWM outputs, registered
- step  output  1  one-cycle pulse on each breathing duty step

## Operation
- Timebase: pwm_cnt counts 0..2^W−2 and wraps to 0 (period P = 2^W−1). Wrap cycle = period boundary.
- Prescaler: per_cnt counts period boundaries 0..STEP_DIV−1; on the boundary where per_cnt = STEP_DIV−1 it wraps and step pulses.
- Per channel, active duty register duty_i latched only at period boundaries (no mid-period glitches):
  - off/reserved: duty_i ← 0; breathe state reset (bduty_i = 0, dir_i = up).
  - steady: duty_i ← level_i sampled at the boundary.
  - breathe: on step, bduty_i ← bduty_i ± 1; direction reverses on reaching 2^W−1 (up) or 0 (down), the extreme value held for exactly one step. duty_i ← bduty_i (post-step value) at every boundary.
- Compare: led_i ← (pwm_cnt < duty_i). duty 0 → always off; duty 2^W−1 → always on.
- Arithmetic unsigned, width W; bduty never wraps modulo 2^W.
- Mode change mid-period: takes effect at the next period boundary. Leaving and re-entering breathe restarts from 0, up.
- en = 0: all counters and registers hold; led holds its last value. step = 0.

## Timing
- Reset (synchronous, rst = 1 on a clk edge): pwm_cnt = 0, per_cnt = 0, all duty_i = 0, bduty_i = 0, dir_i = up, led = 0, step = 0. Reset dominates en.
- led latency: 1 cycle from pwm_cnt value to led.
- Duty latency: new level/mode visible on led at most P+1 cycles after applied.
- step asserts in the same cycle the boundary is registered; breathing full cycle = 2·(2^W−1)·STEP_DIV·P cycles.
- STEP_DIV = 1: step pulses every period boundary.

## Configuration
- PWM_BREATHE_GAMMA_EN defined: compare uses gamma-corrected duty g = (duty·duty) >> W, except duty 2^W−1 maps to 2^W−1 (full on preserved); applies to steady and breathe.
- Undefined: compare uses duty directly (linear).
- Reset values, latency and step timing identical in both builds.

## Structure
- Package pwm_breathe_pkg: mode constants MODE_OFF, MODE_STEADY, MODE_BREATHE, MODE_RSVD; direction constants DIR_UP, DIR_DOWN.
- Top holds timebase, prescaler, step generation; generate loop instantiates sub-module pwm_breathe_ch (one per channel: mode decode, breathe state, duty register, optional gamma, output register).

## Test plan
- Params W=4, STEP_DIV=2, CH=2 (P = 15) unless stated.
- Reset: assert rst mid-period with ch0 steady level 8 -> next cycle led = 0, pwm_cnt = 0; after release ch0 high exactly 8 of every 15 cycles.
- Steady extremes: ch0 level 0, ch1 level 15 -> ch0 never high, ch1 always high after first boundary + 1 cycle.
- Breathe: ch0 breathe -> measured high count per period rises 0,1,…,15 (each value held 2 periods), then 14,…,0; step pulses every 30 cycles.
- Mode change mid-period: switch ch1 steady 4 → steady 12 at pwm_cnt = 6 -> current period keeps 4 high cycles, next period shows 12.
- en low for 50 cycles during breathe -> led, duty and step frozen; resumes same sequence after en = 1.
- Gamma build (PWM_BREATHE_GAMMA_EN, W=4): steady level 8 -> 4 high cycles per period; level 15 -> always high.
